// File: rtl/debug_step_ctrl_if.sv
// ---------------------------------------------------------------------------
// debug_step_ctrl_if
// Groups the debug-panel inputs, the CPU status the step controller watches,
// and the control/status lines it returns to the CPU control unit.
//   sw_debug   : halt/step mode request level (asynchronous)
//   btn_step   : raw, bouncing step push-button (asynchronous)
//   burst_n    : steps per press (0 treated as 1)
//   pc         : current CPU program counter
//   bp_addr    : breakpoint address
//   bp_en      : breakpoint enable
//   debug_en   : suspend the CPU except on step edges
//   debug_step : each rising edge grants one CPU cycle
//   halted     : controller is parked in HALT
//   bp_hit     : sticky breakpoint-halt flag
//   steps_done : count of issued step pulses (wraps)
// master = panel/CPU side, slave = debug_step_ctrl.
// ---------------------------------------------------------------------------
interface debug_step_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             sw_debug;
    logic             btn_step;
    logic [7:0]       burst_n;
    logic [31:0]      pc;
    logic [31:0]      bp_addr;
    logic             bp_en;
    logic             debug_en;
    logic             debug_step;
    logic             halted;
    logic             bp_hit;
    logic [CNT_W-1:0] steps_done;

    modport master (
        output sw_debug, btn_step, burst_n, pc, bp_addr, bp_en,
        input  debug_en, debug_step, halted, bp_hit, steps_done
    );

    modport slave (
        input  sw_debug, btn_step, burst_n, pc, bp_addr, bp_en,
        output debug_en, debug_step, halted, bp_hit, steps_done
    );
endinterface

// File: rtl/debug_step_ctrl.sv
// ---------------------------------------------------------------------------
// debug_step_ctrl
// Single-step / breakpoint controller for a CPU. Synchronizes the debug
// switch and step button, debounces the button, and sequences bursts of
// one-cycle step pulses. Halts on the switch or on a PC breakpoint.
// Ports:
//   clk  : main clock
//   rst  : synchronous active-high reset
//   dbg  : debug_step_ctrl_if.slave (panel inputs, PC/breakpoint, CPU control
//          and status outputs); all outputs are registered.
// ---------------------------------------------------------------------------
module debug_step_ctrl #(
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    debug_step_ctrl_if.slave  dbg
);
    localparam int DW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_HALT,
        S_STEP_HI,
        S_STEP_LO
    } state_e;

    // synchronizers / debouncer
    logic          sw_s1_q, sw_s2_q;
    logic          btn_s1_q, btn_s2_q;
    logic          deb_q, deb_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          step_req_q;
    logic [31:0]   pc_prev_q;

    // step FSM
    state_e           state_q, state_d;
    logic [7:0]       rem_q, rem_d;
    logic             bp_hit_q, bp_hit_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic             debug_en_q, debug_en_d;
    logic             debug_step_q, debug_step_d;
    logic             halted_q, halted_d;

    logic bp_match;

    // Breakpoint fires only on the cycle the PC lands on bp_addr, so a CPU
    // parked on the breakpoint address can be resumed without re-hitting.
    assign bp_match = dbg.bp_en && (dbg.pc != pc_prev_q) && (dbg.pc == dbg.bp_addr);

    // Debouncer: the output follows the synchronized button only after it
    // has disagreed for DEB_CYCLES consecutive cycles; agreement clears it.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (btn_s2_q != deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_d = btn_s2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1_q    <= 1'b0;
            sw_s2_q    <= 1'b0;
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            deb_q      <= 1'b0;
            deb_cnt_q  <= '0;
            step_req_q <= 1'b0;
            pc_prev_q  <= '0;
        end else begin
            sw_s1_q    <= dbg.sw_debug;
            sw_s2_q    <= sw_s1_q;
            btn_s1_q   <= dbg.btn_step;
            btn_s2_q   <= btn_s1_q;
            deb_q      <= deb_d;
            deb_cnt_q  <= deb_cnt_d;
            step_req_q <= deb_d & ~deb_q;
            pc_prev_q  <= dbg.pc;
        end
    end

    // Next-state logic. steps_done is bumped on every entry to STEP_HI so it
    // changes on the same edge that raises debug_step.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        bp_hit_d = bp_hit_q;
        steps_d  = steps_q;
        unique case (state_q)
            S_RUN: begin
                if (bp_match) begin
                    state_d  = S_HALT;
                    bp_hit_d = 1'b1;
                end else if (sw_s2_q) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                if (!sw_s2_q) begin
                    // Switch released: leave at once, unless parked on a
                    // breakpoint, in which case a press resumes past it.
                    if (!bp_hit_q) begin
                        state_d = S_RUN;
                    end else if (step_req_q) begin
                        bp_hit_d = 1'b0;
                        state_d  = S_RUN;
                    end
                end else if (step_req_q) begin
                    rem_d   = (dbg.burst_n == 8'd0) ? 8'd1 : dbg.burst_n;
                    state_d = S_STEP_HI;
                    steps_d = steps_q + CNT_W'(1);
                end
            end
            S_STEP_HI: begin
                state_d = S_STEP_LO;
            end
            S_STEP_LO: begin
                rem_d = rem_q - 8'd1;
                if (bp_match) begin
                    bp_hit_d = 1'b1;
                    state_d  = S_HALT;
                end else if (rem_d == 8'd0) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_STEP_HI;
                    steps_d = steps_q + CNT_W'(1);
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        debug_en_d   = (state_d != S_RUN);
        debug_step_d = (state_d == S_STEP_HI);
        halted_d     = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_RUN;
            rem_q        <= '0;
            bp_hit_q     <= 1'b0;
            steps_q      <= '0;
            debug_en_q   <= 1'b0;
            debug_step_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            bp_hit_q     <= bp_hit_d;
            steps_q      <= steps_d;
            debug_en_q   <= debug_en_d;
            debug_step_q <= debug_step_d;
            halted_q     <= halted_d;
        end
    end

    assign dbg.debug_en   = debug_en_q;
    assign dbg.debug_step = debug_step_q;
    assign dbg.halted     = halted_q;
    assign dbg.bp_hit     = bp_hit_q;
    assign dbg.steps_done = steps_q;

endmodule

// File: tb/tb_debug_step_ctrl.sv
// ---------------------------------------------------------------------------
// tb_debug_step_ctrl
// Bench for debug_step_ctrl: table of burst presses with a pulse-count
// scoreboard, plus hand-written bounce, breakpoint and reset sequences.
// ---------------------------------------------------------------------------
module tb_debug_step_ctrl;
    localparam int DEB = 16;
    localparam int CW  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    debug_step_ctrl_if #(.CNT_W(CW)) dif ();

    debug_step_ctrl #(.DEB_CYCLES(DEB), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .dbg (dif)
    );

    typedef struct {
        logic [7:0] burst;
        logic [7:0] alt;
        int         exp_pulses;
    } vec_t;

    vec_t vt[5];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pulse_cnt = 0;
    int pulse_t[$];
    int exp_q[$];
    int exp_steps = 0;
    bit prev_step = 1'b0;
    bit alt_en = 1'b0;
    logic [7:0] burst_alt = 8'd0;

    // Simple CPU model: advances PC by 4 whenever it is allowed a cycle.
    logic [31:0] pc_man;
    logic [31:0] pc_mdl;
    bit cpu_run = 1'b0;
    assign dif.pc = cpu_run ? pc_mdl : pc_man;
    always @(posedge clk) begin
        if (!cpu_run) pc_mdl <= pc_man;
        else if (!dif.debug_en || dif.debug_step) pc_mdl <= pc_mdl + 32'd4;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // One clock; sample just after the edge and log step pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (dif.debug_step) begin
            pulse_cnt++;
            pulse_t.push_back(cyc);
            check("step_not_adjacent", 32'(prev_step), 32'd0);
            if (alt_en) dif.burst_n = burst_alt;
        end
        prev_step = dif.debug_step;
    endtask

    task automatic press();
        dif.btn_step = 1'b1;
        repeat (DEB + 5) tick();
        dif.btn_step = 1'b0;
        repeat (DEB + 5) tick();
    endtask

    task automatic wait_halt(input string nm);
        int n = 0;
        while (!dif.halted && n < 200) begin
            tick();
            n++;
        end
        check(nm, 32'(dif.halted), 32'd1);
    endtask

    task automatic sb_check(input string nm, input int base);
        int e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty, got %0d pulses", nm, pulse_cnt - base);
        end else begin
            e = exp_q.pop_front();
            check(nm, 32'(pulse_cnt - base), 32'(e));
        end
    endtask

    task automatic check_reset_outs(input string nm);
        check({nm, "_en"},     32'(dif.debug_en),   32'd0);
        check({nm, "_step"},   32'(dif.debug_step), 32'd0);
        check({nm, "_halted"}, 32'(dif.halted),     32'd0);
        check({nm, "_bphit"},  32'(dif.bp_hit),     32'd0);
        check({nm, "_steps"},  32'(dif.steps_done), 32'd0);
    endtask

    initial begin
        int base;
        int t0;
        int n;

        vt[0] = '{burst: 8'd0, alt: 8'd3, exp_pulses: 1};
        vt[1] = '{burst: 8'd1, alt: 8'd4, exp_pulses: 1};
        vt[2] = '{burst: 8'd5, alt: 8'd2, exp_pulses: 5};
        vt[3] = '{burst: 8'd3, alt: 8'd9, exp_pulses: 3};
        vt[4] = '{burst: 8'd2, alt: 8'd1, exp_pulses: 2};

        rst          = 1'b1;
        dif.sw_debug = 1'b0;
        dif.btn_step = 1'b0;
        dif.burst_n  = 8'd0;
        dif.bp_addr  = 32'd0;
        dif.bp_en    = 1'b0;
        pc_man       = 32'd0;
        repeat (3) tick();
        check_reset_outs("reset");
        rst = 1'b0;
        repeat (3) tick();
        check("run_after_reset", 32'(dif.debug_en), 32'd0);

        // switch to halt: two sync flops plus the state register
        dif.sw_debug = 1'b1;
        repeat (2) tick();
        check("sw_not_yet_halted", 32'(dif.halted), 32'd0);
        tick();
        check("sw_halted", 32'(dif.halted), 32'd1);
        check("sw_debug_en", 32'(dif.debug_en), 32'd1);

        // table-driven bursts; burst_n is changed after the first pulse
        for (int i = 0; i < 5; i++) begin
            dif.burst_n = vt[i].burst;
            burst_alt   = vt[i].alt;
            alt_en      = 1'b1;
            base        = pulse_cnt;
            t0          = pulse_t.size();
            exp_q.push_back(vt[i].exp_pulses);
            exp_steps  += vt[i].exp_pulses;
            press();
            alt_en = 1'b0;
            wait_halt($sformatf("vec%0d_halt", i));
            sb_check($sformatf("vec%0d_pulses", i), base);
            check($sformatf("vec%0d_steps_done", i), 32'(dif.steps_done), 32'(exp_steps));
            for (int k = t0 + 1; k < pulse_t.size(); k++)
                check($sformatf("vec%0d_period", i), 32'(pulse_t[k] - pulse_t[k-1]), 32'd2);
        end

        // bouncing button: no step while bouncing, one after a clean press
        dif.burst_n = 8'd1;
        base = pulse_cnt;
        for (int k = 0; k < 40; k++) begin
            if (k % 3 == 0) dif.btn_step = ~dif.btn_step;
            tick();
        end
        check("bounce_no_pulse", 32'(pulse_cnt - base), 32'd0);
        dif.btn_step = 1'b0;
        repeat (DEB + 5) tick();
        base = pulse_cnt;
        exp_q.push_back(1);
        exp_steps += 1;
        press();
        wait_halt("bounce_halt");
        sb_check("bounce_one_pulse", base);
        check("bounce_steps_done", 32'(dif.steps_done), 32'(exp_steps));

        // release switch -> RUN
        dif.sw_debug = 1'b0;
        repeat (3) tick();
        check("resume_halted", 32'(dif.halted), 32'd0);
        check("resume_debug_en", 32'(dif.debug_en), 32'd0);

        // breakpoint while running: pc 0x0C -> 0x10
        pc_man      = 32'h0000_000C;
        dif.bp_addr = 32'h0000_0010;
        dif.bp_en   = 1'b1;
        repeat (2) tick();
        check("bp_pre_halted", 32'(dif.halted), 32'd0);
        pc_man = 32'h0000_0010;
        tick();
        check("bp_halted", 32'(dif.halted), 32'd1);
        check("bp_hit_set", 32'(dif.bp_hit), 32'd1);
        check("bp_debug_en", 32'(dif.debug_en), 32'd1);
        repeat (3) tick();
        check("bp_stays_halted", 32'(dif.halted), 32'd1);
        base = pulse_cnt;
        press();
        check("bp_resume_halted", 32'(dif.halted), 32'd0);
        check("bp_resume_hit", 32'(dif.bp_hit), 32'd0);
        check("bp_resume_en", 32'(dif.debug_en), 32'd0);
        check("bp_resume_no_pulse", 32'(pulse_cnt - base), 32'd0);
        repeat (5) tick();
        check("bp_no_rehit", 32'(dif.halted), 32'd0);

        // burst of 10 stopped by breakpoint at the third step
        dif.bp_en    = 1'b0;
        dif.sw_debug = 1'b1;
        repeat (3) tick();
        check("bpb_halted", 32'(dif.halted), 32'd1);
        cpu_run     = 1'b1;
        dif.bp_addr = 32'h0000_001C;
        dif.bp_en   = 1'b1;
        dif.burst_n = 8'd10;
        base = pulse_cnt;
        exp_q.push_back(3);
        exp_steps += 3;
        press();
        wait_halt("bpb_halt");
        sb_check("bpb_pulses", base);
        check("bpb_steps_done", 32'(dif.steps_done), 32'(exp_steps));
        check("bpb_hit", 32'(dif.bp_hit), 32'd1);
        check("bpb_pc", dif.pc, 32'h0000_001C);

        // reset during STEP_LO of a 5-step burst
        dif.bp_en   = 1'b0;
        cpu_run     = 1'b0;
        dif.burst_n = 8'd5;
        dif.btn_step = 1'b1;
        n = 0;
        while (!dif.debug_step && n < 100) begin
            tick();
            n++;
        end
        check("rst_burst_started", 32'(dif.debug_step), 32'd1);
        tick();
        check("rst_in_step_lo", 32'(dif.debug_step), 32'd0);
        check("rst_in_step_lo_en", 32'(dif.debug_en), 32'd1);
        rst = 1'b1;
        dif.btn_step = 1'b0;
        tick();
        check_reset_outs("midburst_rst");
        rst = 1'b0;
        base = pulse_cnt;
        repeat (40) tick();
        check("rst_no_more_pulses", 32'(pulse_cnt - base), 32'd0);
        check("rst_steps_cleared", 32'(dif.steps_done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
